// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one external pipelined multiplier
// between NUM_REQ requesters and routes each product back by tag.
module mul_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = INPUT_WIDTH * 2,
  parameter int MUL_LATENCY  = 3,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b,
  output logic                           mul_en,
  output logic [INPUT_WIDTH-1:0]         mul_a,
  output logic [INPUT_WIDTH-1:0]         mul_b,
  input  logic [OUTPUT_WIDTH-1:0]        mul_data_in,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [OUTPUT_WIDTH-1:0]        resp_data,
  output logic [ID_W+1:0]                inflight,
  input  logic                           enable
);

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic                    grant_vld;
  logic [ID_W-1:0]         grant_id;
  logic [MUL_LATENCY-1:0]  tag_vld_q;
  logic [ID_W-1:0]         tag_id_q [MUL_LATENCY];
  logic                    retire;
  logic [ID_W-1:0]         retire_id;
  logic [OUTPUT_WIDTH-1:0] resp_data_q;
  logic [ID_W+1:0]         inflight_q, inflight_d;

  // The multiplier free-runs; empty slots are tracked by the tag valid bits.
  assign mul_en = ~reset;

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && enable && !reset &&
          req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    ptr_d     = ptr_q;
    if (grant_vld) begin
      req_ready[grant_id] = 1'b1;
      mul_a = req_a[grant_id*INPUT_WIDTH +: INPUT_WIDTH];
      mul_b = req_b[grant_id*INPUT_WIDTH +: INPUT_WIDTH];
      ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  assign retire    = tag_vld_q[MUL_LATENCY-1];
  assign retire_id = tag_id_q[MUL_LATENCY-1];

  always_comb begin
    resp_valid = '0;
    resp_data  = resp_data_q;
    if (retire) begin
      resp_valid[retire_id] = 1'b1;
      resp_data = mul_data_in;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (grant_vld && !retire)      inflight_d = inflight_q + 1'b1;
    else if (!grant_vld && retire) inflight_d = inflight_q - 1'b1;
  end

  assign inflight = inflight_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      resp_data_q <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_vld_q[0] <= grant_vld;
      for (int s = 1; s < MUL_LATENCY; s++) tag_vld_q[s] <= tag_vld_q[s-1];
      resp_data_q  <= resp_data;
      inflight_q   <= inflight_d;
    end
  end

  // NOTE: tag ids are payload qualified by the valid bits, so they are left
  // out of reset; clearing the valid bits alone discards in-flight work.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant_id;
    for (int s = 1; s < MUL_LATENCY; s++) tag_id_q[s] <= tag_id_q[s-1];
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared with a
// queue-based reference of grants and expected product returns.
module tb_mul_share_arbiter;

  localparam int N   = 4;
  localparam int IW  = 16;
  localparam int OW  = 32;
  localparam int LAT = 3;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_a;
  logic [N*IW-1:0] req_b;
  logic            mul_en;
  logic [IW-1:0]   mul_a;
  logic [IW-1:0]   mul_b;
  logic [OW-1:0]   mul_data_in;
  logic [N-1:0]    resp_valid;
  logic [OW-1:0]   resp_data;
  logic [3:0]      inflight;
  logic            enable;

  mul_share_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(IW), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_data_in(mul_data_in), .resp_valid(resp_valid), .resp_data(resp_data),
    .inflight(inflight), .enable(enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External multiplier: LAT-stage free-running pipeline, not reset.
  logic [OW-1:0] p0, p1, p2;
  always @(posedge clk) begin
    if (mul_en) begin
      p0 <= mul_a * mul_b;
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign mul_data_in = p2;

  typedef struct {
    int          due;
    int          id;
    logic [63:0] prod;
  } ent_t;

  ent_t        pend[$];
  int          ptr;
  int          cyc;
  logic [63:0] last_data;
  logic [IW-1:0] a_v [N];
  logic [IW-1:0] b_v [N];
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the reference model.
  task automatic step(input logic [N-1:0] v, input logic en, input logic rst_v);
    int          g;
    logic [N-1:0] exp_rv;
    logic [63:0] exp_rd;
    reset     = rst_v;
    req_valid = v;
    enable    = en;
    for (int i = 0; i < N; i++) begin
      req_a[i*IW +: IW] = a_v[i];
      req_b[i*IW +: IW] = b_v[i];
    end
    if (rst_v) begin
      pend.delete();
      ptr       = 0;
      last_data = '0;
    end
    @(negedge clk);
    g = -1;
    if (en && !rst_v)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
    check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
    check("mul_a", 64'(mul_a), (g >= 0) ? 64'(a_v[g]) : 64'(0));
    check("mul_b", 64'(mul_b), (g >= 0) ? 64'(b_v[g]) : 64'(0));
    check("mul_en", 64'(mul_en), 64'(!rst_v));
    check("inflight", 64'(inflight), 64'(pend.size()));
    exp_rv = '0;
    exp_rd = last_data;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv[pend[0].id] = 1'b1;
      exp_rd    = pend[0].prod;
      last_data = pend[0].prod;
      void'(pend.pop_front());
    end
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    check("resp_data", 64'(resp_data), exp_rd);
    @(posedge clk);
    if (g >= 0) begin
      pend.push_back('{due: cyc + LAT, id: g, prod: 64'(a_v[g]) * 64'(b_v[g])});
      ptr = (g + 1) % N;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    ptr       = 0;
    last_data = '0;
    reset     = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    #1;
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);

    // Single requester
    a_v[1] = 16'd3;
    b_v[1] = 16'd5;
    step(4'b0010, 1'b1, 1'b0);
    idle(4);

    // All requesters continuously valid
    for (int i = 0; i < N; i++) begin
      a_v[i] = 16'(i + 1);
      b_v[i] = 16'd10;
    end
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 1'b0);
    idle(4);

    // Back-to-back single requester at maximum operands
    a_v[2] = 16'hFFFF;
    b_v[2] = 16'hFFFF;
    for (int i = 0; i < 4; i++) step(4'b0100, 1'b1, 1'b0);
    idle(4);

    // Wrap-around after a grant to the last requester
    a_v[0] = 16'd7;
    a_v[3] = 16'd9;
    step(4'b1000, 1'b1, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    step(4'b1001, 1'b1, 1'b0);
    idle(4);

    // Enable dropped mid-stream
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    idle(4);

    // Reset while two operations are in flight
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b1);
    idle(3);
    step(4'b1111, 1'b1, 1'b0);
    idle(4);

    // Random traffic with occasional enable drops and resets
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < N; r++) begin
        a_v[r] = 16'($urandom);
        b_v[r] = 16'($urandom);
      end
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 99) == 0));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 16x16 multiplier between NUM_REQ requesters, e.g. the PE lanes of a row.
- Each requester issues operand pairs over a valid/ready handshake.
- A round-robin arbiter grants at most one operand pair per cycle into the multiplier.
- A tag pipeline matched to the multiplier latency routes each product back to its requester with a response strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- INPUT_WIDTH, 16, operand width.
- OUTPUT_WIDTH, INPUT_WIDTH*2, product width.
- MUL_LATENCY, 3, clock edges from operand sample to product on mul_data_out.
- ID_W, $clog2(NUM_REQ), tag width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*INPUT_WIDTH  packed operand A; requester i at [i*INPUT_WIDTH +: INPUT_WIDTH]
- req_b  in  NUM_REQ*INPUT_WIDTH  packed operand B, same packing
- mul_en  out  1  multiplier pipeline enable
- mul_a  out  INPUT_WIDTH  operand A to multiplier
- mul_b  out  INPUT_WIDTH  operand B to multiplier
- mul_data_in  in  OUTPUT_WIDTH  product from multiplier
- resp_valid  out  NUM_REQ  one-hot product strobe
- resp_data  out  OUTPUT_WIDTH  product, shared by all requesters
- inflight  out  ID_W+2  number of operations in the multiplier pipeline
- enable  in  1  when low, no new grants; in-flight operations still drain

Behaviour:
- Reset (asynchronous, active-high):
  - req_ready, resp_valid, mul_a, mul_b, resp_data and inflight go to 0.
  - Tag pipeline valid bits clear.
  - Round-robin pointer resets to 0, so requester 0 has top priority.
  - mul_en is 0 while reset is high.
- mul_en: 1 every cycle outside reset. The multiplier free-runs; bubbles are tracked by the tag pipeline, not by stalling.
- Arbitration: combinational within a cycle.
  - Search req_valid starting at the pointer, wrapping modulo NUM_REQ.
  - The first set bit i gets req_ready[i]=1, only if enable=1.
  - A transfer occurs when req_valid[i] and req_ready[i] are both 1.
  - req_ready never asserts for a requester whose req_valid is low.
- Pointer update: on a transfer to i, the pointer becomes (i+1) mod NUM_REQ on the next edge. With no transfer the pointer holds.
- Operand drive:
  - mul_a and mul_b are the combinational mux of the granted requester's operands.
  - With no grant, mul_a and mul_b are 0. This is harmless because that slot is marked invalid.
- Tag pipeline:
  - MUL_LATENCY stages of {valid, id}.
  - Stage 0 captures {transfer, i} at each edge.
  - At stage MUL_LATENCY-1 output (the same cycle mul_data_in holds that product):
    - resp_valid[id] = valid, all other bits 0.
    - resp_data = mul_data_in when valid, otherwise holds its last value.
  - Response is combinational from the tag stage, so total latency is MUL_LATENCY cycles from the accepting edge.
- Responses cannot be back-pressured. Requesters must consume resp_valid in the cycle it is asserted.
- Throughput: one grant per cycle overall. One requester alone gets back-to-back grants. With k active requesters, each is granted once every k cycles.
- inflight:
  - Equals the count of set valid bits in the tag pipeline.
  - +1 on a transfer, -1 on a retiring valid stage, unchanged when both happen in the same cycle.
  - Maximum value is MUL_LATENCY.
- enable low mid-stream: the current cycle issues nothing, and the tag pipeline keeps shifting and draining. When enable returns high, arbitration resumes from the held pointer.
- Reset mid-operation: in-flight tags are discarded and no resp_valid is produced for them. This holds even though the multiplier's own registers may retain stale data.
- Operand values are treated as unsigned; the product is the full OUTPUT_WIDTH.

Test Plan:
- Single requester: req_valid=4'b0010, a=3, b=5 for one cycle -> req_ready=4'b0010 that cycle; 3 cycles later resp_valid=4'b0010, resp_data=15; inflight goes 1,1,1 then 0.
- All requesters continuously valid, operands a=i+1, b=10 -> grants follow 0,1,2,3,0,...; resp_valid repeats the same order 3 cycles later with data 10,20,30,40.
- Back-to-back, requester 2 alone with a=0xFFFF, b=0xFFFF for 4 cycles -> 4 consecutive resp_valid=4'b0100, each with resp_data=0xFFFE0001; inflight saturates at 3.
- Pointer after a grant to 3, then req_valid=4'b1001 -> requester 0 is granted next (wrap-around), then requester 3.
- Requesters 0 and 1 valid, enable dropped for 2 cycles after one grant -> req_ready=0 during those cycles; the pending product still returns on schedule; the grant after enable rises goes to requester 1.
- Reset pulsed while inflight=2 -> all outputs 0 immediately; no resp_valid in the following 3 cycles; the next grant goes to requester 0.
